// File: rtl/rom_loader_packer.sv
// Packs iosys loader bytes into big-endian 16-bit words, queues them in a small FIFO and
// writes them to SDRAM through a toggle req/ack handshake; owns md_on and rom_size.
module rom_loader_packer #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_BITS  = 22
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2:0]           loading,
   input  logic [7:0]           loader_do,
   input  logic                 loader_do_valid,
   output logic [ADDR_BITS-2:0] mem_addr,
   output logic [15:0]          mem_din,
   output logic [1:0]           mem_be,
   output logic                 mem_req,
   input  logic                 mem_ack,
   output logic                 md_on,
   output logic [ADDR_BITS-1:0] rom_size,
   output logic                 overflow,
   output logic                 idle
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = (ADDR_BITS - 1) + 16 + 2;

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2, RUN = 2'd3} state_t;

   state_t                 state_r, state_s;
   logic                   load_r;
   logic                   start_s, end_s;
   logic [ADDR_BITS-1:0]   count_r;
   logic [7:0]             hold_r;
   logic [EW-1:0]          fifo_r [FIFO_DEPTH];
   logic [PW:0]            wr_ptr_r, rd_ptr_r;
   logic                   empty_s, full_s;
   logic                   push_s, push_ok_s, pop_s;
   logic [EW-1:0]          push_word_s;
   logic                   ack_prev_r, ack_tgl_s, pending_r;
   logic                   idle_s;

   assign start_s   = (loading != 3'd0) && !load_r;
   assign end_s     = (loading == 3'd0) && load_r;
   assign empty_s   = (wr_ptr_r == rd_ptr_r);
   assign full_s    = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
   // Completion is a toggle of mem_ack, so an ack left over from before a reset is harmless.
   assign ack_tgl_s = (mem_ack != ack_prev_r);
   assign idle_s    = empty_s && !pending_r;
   assign idle      = idle_s;
   // A word leaves the FIFO the moment it is issued; the output registers hold it until acked.
   assign pop_s     = !start_s && !empty_s && (!pending_r || ack_tgl_s);
   assign push_ok_s = push_s && (!full_s || pop_s);

   // Session state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic: a start edge always wins.
   always_comb begin
      state_s = state_r;
      if (start_s) begin
         state_s = LOAD;
      end else begin
         case (state_r)
            LOAD:    if (end_s) state_s = DRAIN; else state_s = LOAD;
            DRAIN:   if (idle_s) state_s = RUN; else state_s = DRAIN;
            default: state_s = state_r;
         endcase
      end
   end

   // Word assembly: full words on odd bytes, a half word flush on an odd-length end edge.
   always_comb begin
      push_s      = 1'b0;
      push_word_s = '0;
      if (state_r == LOAD && !start_s) begin
         if (end_s) begin
            if (count_r[0]) begin
               push_s      = 1'b1;
               push_word_s = {count_r[ADDR_BITS-1:1], hold_r, 8'h00, 2'b10};
            end else begin
               push_s = 1'b0;
            end
         end else if (loader_do_valid && count_r[0]) begin
            push_s      = 1'b1;
            push_word_s = {count_r[ADDR_BITS-1:1], hold_r, loader_do, 2'b11};
         end else begin
            push_s = 1'b0;
         end
      end else begin
         push_s = 1'b0;
      end
   end

   // FIFO storage needs no reset; validity is carried by the pointers.
   always_ff @(posedge clk) begin
      if (push_ok_s && !start_s) begin
         fifo_r[wr_ptr_r[PW-1:0]] <= push_word_s;
      end
   end

   // Datapath, issuer and status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         load_r     <= 1'b0;
         count_r    <= '0;
         hold_r     <= 8'h00;
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         ack_prev_r <= mem_ack;
         pending_r  <= 1'b0;
         mem_addr   <= '0;
         mem_din    <= 16'h0000;
         mem_be     <= 2'b00;
         mem_req    <= 1'b0;
         md_on      <= 1'b0;
         rom_size   <= '0;
         overflow   <= 1'b0;
      end else begin
         load_r     <= (loading != 3'd0);
         ack_prev_r <= mem_ack;
         if (ack_tgl_s) pending_r <= 1'b0;
         if (pop_s) begin
            {mem_addr, mem_din, mem_be} <= fifo_r[rd_ptr_r[PW-1:0]];
            mem_req   <= ~mem_req;
            pending_r <= 1'b1;
            rd_ptr_r  <= rd_ptr_r + (PW+1)'(1);
         end
         if (start_s) begin
            count_r  <= '0;
            hold_r   <= 8'h00;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            overflow <= 1'b0;
         end else begin
            if (push_ok_s) begin
               wr_ptr_r <= wr_ptr_r + (PW+1)'(1);
            end else if (push_s) begin
               overflow <= 1'b1;
            end
            if (state_r == LOAD && !end_s && loader_do_valid) begin
               count_r <= count_r + ADDR_BITS'(1);
               if (!count_r[0]) hold_r <= loader_do;
            end
         end
         md_on <= (state_s == RUN);
         if (state_r == DRAIN && state_s == RUN) rom_size <= count_r;
      end
   end

endmodule

// File: tb/tb_rom_loader_packer.sv
// Self-checking bench for rom_loader_packer: a toggle-ack SDRAM responder records every
// write, and expected words are derived from the byte list by simple pairing rules.
module tb_rom_loader_packer;

   typedef logic [7:0]  byte_q_t[$];
   typedef logic [38:0] word_q_t[$];

   logic        clk;
   logic        reset;
   logic [2:0]  loading;
   logic [7:0]  loader_do;
   logic        loader_do_valid;
   logic [20:0] mem_addr;
   logic [15:0] mem_din;
   logic [1:0]  mem_be;
   logic        mem_req;
   logic        mem_ack;
   logic        md_on;
   logic [21:0] rom_size;
   logic        overflow;
   logic        idle;

   int          checks;
   int          failures;
   int          ack_delay;
   bit          resp_en;
   logic        req_seen;
   logic [38:0] wr_q[$];

   rom_loader_packer #(.FIFO_DEPTH(4), .ADDR_BITS(22)) dut (
      .clk(clk), .reset(reset), .loading(loading), .loader_do(loader_do),
      .loader_do_valid(loader_do_valid), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_be(mem_be), .mem_req(mem_req), .mem_ack(mem_ack), .md_on(md_on),
      .rom_size(rom_size), .overflow(overflow), .idle(idle)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // SDRAM side: record each new request, acknowledge it ack_delay cycles later.
   task automatic responder();
      forever begin
         @(negedge clk);
         if (resp_en && mem_req !== req_seen) begin
            req_seen = mem_req;
            wr_q.push_back({mem_addr, mem_din, mem_be});
            repeat (ack_delay) @(negedge clk);
            mem_ack = req_seen;
         end
      end
   endtask

   task automatic build_expected(input byte_q_t b, output word_q_t e);
      e = {};
      for (int i = 0; i < b.size(); i += 2) begin
         if (i + 1 < b.size()) e.push_back({21'(i / 2), b[i], b[i+1], 2'b11});
         else                  e.push_back({21'(i / 2), b[i], 8'h00, 2'b10});
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; mem_ack = 1'b0; req_seen = 1'b0;
      loading = 3'd0; loader_do_valid = 1'b0; loader_do = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_load(input byte_q_t b, input int gap, input logic [2:0] mode,
                           output bit timed_out);
      wr_q.delete();
      @(negedge clk);
      loading = mode;
      repeat (2) @(negedge clk);
      foreach (b[i]) begin
         loader_do = b[i]; loader_do_valid = 1'b1;
         @(negedge clk);
         loader_do_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      @(negedge clk);
      loading = 3'd0;
      timed_out = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (md_on === 1'b1) begin timed_out = 1'b0; break; end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({md_on, mem_req, mem_addr, mem_din, mem_be} !== 41'd0) begin
         $display("FAIL reset_outputs got md_on=%b req=%b addr=%h din=%h be=%b want all 0",
                  md_on, mem_req, mem_addr, mem_din, mem_be);
         failures++;
      end
      checks++;
      if (rom_size !== 22'd0 || overflow !== 1'b0 || idle !== 1'b1) begin
         $display("FAIL reset_status got rom_size=%0d overflow=%b idle=%b want 0 0 1",
                  rom_size, overflow, idle);
         failures++;
      end
   endtask

   task automatic test_even_load();
      bit to;
      ack_delay = 3;
      run_load('{8'h11, 8'h22, 8'h33, 8'h44}, 1, 3'd1, to);
      checks++;
      if (to) begin $display("FAIL even_md_on got timeout want md_on=1"); failures++; end
      checks++;
      if (wr_q.size() != 2) begin
         $display("FAIL even_count got %0d want 2", wr_q.size()); failures++;
      end else begin
         checks++;
         if (wr_q[0] !== {21'd0, 16'h1122, 2'b11} || wr_q[1] !== {21'd1, 16'h3344, 2'b11}) begin
            $display("FAIL even_words got %h %h want %h %h", wr_q[0], wr_q[1],
                     {21'd0, 16'h1122, 2'b11}, {21'd1, 16'h3344, 2'b11});
            failures++;
         end
      end
      checks++;
      if (rom_size !== 22'd4 || md_on !== 1'b1 || overflow !== 1'b0) begin
         $display("FAIL even_status got rom_size=%0d md_on=%b overflow=%b want 4 1 0",
                  rom_size, md_on, overflow);
         failures++;
      end
   endtask

   task automatic test_odd_load();
      bit to;
      do_reset();
      ack_delay = 2;
      run_load('{8'hAA, 8'hBB, 8'hCC}, 2, 3'd1, to);
      checks++;
      if (to || wr_q.size() != 2) begin
         $display("FAIL odd_count got %0d timeout=%b want 2 0", wr_q.size(), to); failures++;
      end else begin
         checks++;
         if (wr_q[0] !== {21'd0, 16'hAABB, 2'b11} || wr_q[1] !== {21'd1, 16'hCC00, 2'b10}) begin
            $display("FAIL odd_words got %h %h want %h %h", wr_q[0], wr_q[1],
                     {21'd0, 16'hAABB, 2'b11}, {21'd1, 16'hCC00, 2'b10});
            failures++;
         end
      end
      checks++;
      if (rom_size !== 22'd3) begin
         $display("FAIL odd_rom_size got %0d want 3", rom_size); failures++;
      end
   endtask

   task automatic test_overflow();
      byte_q_t b;
      word_q_t e;
      bit to;
      do_reset();
      ack_delay = 20;
      for (int i = 0; i < 16; i++) b.push_back(8'($urandom));
      build_expected(b, e);
      run_load(b, 0, 3'd3, to);
      checks++;
      if (to) begin $display("FAIL ovf_md_on got timeout want md_on=1"); failures++; end
      checks++;
      if (wr_q.size() != 5) begin
         $display("FAIL ovf_count got %0d want 5", wr_q.size()); failures++;
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (wr_q[i] !== e[i]) begin
               $display("FAIL ovf_word%0d got %h want %h", i, wr_q[i], e[i]); failures++;
            end
         end
      end
      checks++;
      if (overflow !== 1'b1 || rom_size !== 22'd16) begin
         $display("FAIL ovf_status got overflow=%b rom_size=%0d want 1 16", overflow, rom_size);
         failures++;
      end
   endtask

   task automatic test_second_load();
      byte_q_t b;
      word_q_t e;
      bit to;
      ack_delay = 1;
      for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
      build_expected(b, e);
      @(negedge clk);
      loading = 3'd2;
      checks++;
      if (md_on !== 1'b1) begin $display("FAIL second_pre got md_on=%b want 1", md_on); failures++; end
      @(negedge clk);
      checks++;
      if (md_on !== 1'b0 || overflow !== 1'b0) begin
         $display("FAIL second_start got md_on=%b overflow=%b want 0 0", md_on, overflow);
         failures++;
      end
      run_load(b, 1, 3'd2, to);
      checks++;
      if (to || wr_q.size() != 2 || wr_q[0] !== e[0] || wr_q[1] !== e[1]) begin
         $display("FAIL second_words got n=%0d timeout=%b want %h %h", wr_q.size(), to, e[0], e[1]);
         failures++;
      end
      checks++;
      if (rom_size !== 22'd4) begin $display("FAIL second_rom_size got %0d want 4", rom_size); failures++; end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         byte_q_t b;
         word_q_t e;
         bit to;
         int n;
         n = int'($urandom_range(1, 11));
         for (int i = 0; i < n; i++) b.push_back(8'($urandom));
         build_expected(b, e);
         ack_delay = int'($urandom_range(1, 3));
         run_load(b, int'($urandom_range(2, 4)), 3'($urandom_range(1, 7)), to);
         checks++;
         if (to || wr_q.size() != e.size()) begin
            $display("FAIL rand%0d_count got %0d timeout=%b want %0d", it, wr_q.size(), to, e.size());
            failures++;
         end else begin
            foreach (e[i]) begin
               checks++;
               if (wr_q[i] !== e[i]) begin
                  $display("FAIL rand%0d_word%0d got %h want %h", it, i, wr_q[i], e[i]); failures++;
               end
            end
         end
         checks++;
         if (rom_size !== 22'(n) || overflow !== 1'b0) begin
            $display("FAIL rand%0d_status got rom_size=%0d overflow=%b want %0d 0",
                     it, rom_size, overflow, n);
            failures++;
         end
      end
   endtask

   task automatic test_valid_idle();
      byte_q_t b;
      bit to;
      b = '{8'h5A, 8'hC3, 8'h7E};
      ack_delay = 2;
      run_load(b, 2, 3'd1, to);
      wr_q.delete();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         loader_do = 8'($urandom); loader_do_valid = 1'b1;
         @(negedge clk);
         loader_do_valid = 1'b0;
      end
      repeat (10) @(negedge clk);
      checks++;
      if (to || wr_q.size() != 0) begin
         $display("FAIL valid_idle_writes got %0d timeout=%b want 0 0", wr_q.size(), to); failures++;
      end
      checks++;
      if (rom_size !== 22'd3 || md_on !== 1'b1 || idle !== 1'b1) begin
         $display("FAIL valid_idle_status got rom_size=%0d md_on=%b idle=%b want 3 1 1",
                  rom_size, md_on, idle);
         failures++;
      end
   endtask

   task automatic test_reset_midload();
      bit seen;
      resp_en = 1'b0;
      do_reset();
      @(negedge clk);
      loading = 3'd1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         loader_do = 8'($urandom); loader_do_valid = 1'b1;
         @(negedge clk);
      end
      loader_do_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (mem_req === 1'b1) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!seen) begin $display("FAIL midload_req got mem_req=%b want 1", mem_req); failures++; end
      reset = 1'b1; loading = 3'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({md_on, mem_req, mem_addr, mem_din, mem_be} !== 41'd0 || rom_size !== 22'd0 ||
          overflow !== 1'b0 || idle !== 1'b1) begin
         $display("FAIL midload_reset got md_on=%b req=%b addr=%h din=%h be=%b rs=%0d ovf=%b idle=%b",
                  md_on, mem_req, mem_addr, mem_din, mem_be, rom_size, overflow, idle);
         failures++;
      end
      mem_ack = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || idle !== 1'b1 || md_on !== 1'b0) begin
         $display("FAIL late_ack got mem_req=%b idle=%b md_on=%b want 0 1 0", mem_req, idle, md_on);
         failures++;
      end
      do_reset();
      resp_en = 1'b1;
   endtask

   initial begin
      checks = 0; failures = 0; ack_delay = 1; resp_en = 1'b1; req_seen = 1'b0;
      reset = 1'b1; loading = 3'd0; loader_do = 8'h00; loader_do_valid = 1'b0; mem_ack = 1'b0;
      fork
         responder();
      join_none
      test_reset();
      test_even_load();
      test_odd_load();
      test_overflow();
      test_second_load();
      test_random();
      test_valid_idle();
      test_reset_midload();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
